sma_window_feeder: RTL and testbench

Upstream operand stage for the sixteen-sample moving-average adder: accepts a stream of unsigned samples, keeps the last DEPTH samples in a circular window, and for every accepted sample presents the ROM adder with the pair {a = new sample, b = sample evicted from the window}. During initial fill, b is forced to 0. The downstream stage forms the running-sum delta from the pair. Window fill status is exported for the averaging logic.

---
 rtl/sma_pkg.sv | 15 +
 rtl/sma_window_ram.sv | 26 ++
 rtl/sma_window_feeder.sv | 103 ++++++++++
 tb/tb_sma_window_feeder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sma_pkg.sv
// Shared widths and the window fill-state enum for the moving-average pipeline.
// The downstream averaging stage reuses sma_fill_state_t.
package sma_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic {
        FILL   = 1'b0,
        STEADY = 1'b1
    } sma_fill_state_t;

endpackage

// File: rtl/sma_window_ram.sv
// DEPTH x DATA_WIDTH window storage: synchronous write, asynchronous read.
// A read of the slot being written returns the old content; no backpressure.
module sma_window_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sma_window_feeder.sv
// Pairs each accepted sample with the one it evicts from the window (0 while filling).
// One-cycle latency through a single output register; stalls upstream while the pair is unconsumed.
module sma_window_feeder
    import sma_pkg::*;
#(
    parameter int DATA_WIDTH = sma_pkg::DATA_WIDTH,
    parameter int DEPTH      = sma_pkg::DEPTH,
    localparam int PTR_BITS  = $clog2(DEPTH),
    localparam int CNT_BITS  = PTR_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic                  window_full,
    output logic [CNT_BITS-1:0]   fill_count
);

    sma_fill_state_t       state_q, state_d;
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] evict_dat;
    logic                  accept;

    // Output register empties or is popped this cycle; never depends on in_valid.
    assign in_ready = !rst && !clear && (!ov_q || op_ready);
    assign accept   = in_valid && in_ready;

    sma_window_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (accept),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_data),
        .raddr_i(wr_ptr_q),
        .rdata_o(evict_dat)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        ov_d     = ov_q;

        if (clear) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            cnt_d    = '0;
            ov_d     = 1'b0;
        end else if (accept) begin
            a_d      = in_data;
            b_d      = (state_q == STEADY) ? evict_dat : '0;
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            ov_d     = 1'b1;
            if (state_q == FILL) begin
                cnt_d = cnt_q + CNT_BITS'(1);
                if (cnt_q == CNT_BITS'(DEPTH - 1)) begin
                    state_d = STEADY;
                end
            end
        end else if (ov_q && op_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ov_q     <= ov_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign op_valid    = ov_q;
    assign window_full = (state_q == STEADY);
    assign fill_count  = cnt_q;

endmodule

// File: tb/tb_sma_window_feeder.sv
// Directed bench for sma_window_feeder: fill/steady streams in loops, corner cases from a vector table.
module tb_sma_window_feeder;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       op_valid;
    logic       op_ready;
    logic       window_full;
    logic [4:0] fill_count;

    int n_cmp = 0;
    int n_bad = 0;

    sma_window_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .window_full(window_full),
        .fill_count (fill_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       rdy;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eov;
        logic       efull;
        logic [4:0] efill;
        logic       chk_ab;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 ns after a rising edge; in_ready is sampled before the next edge.
    task automatic drive(input logic r, input logic c, input logic iv, input logic [7:0] d,
                         input logic ordy);
        rst      = r;
        clear    = c;
        in_valid = iv;
        in_data  = d;
        op_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                            input logic eov, input logic efull, input logic [4:0] efill);
        chk({tag, ".a"}, 32'(a), 32'(ea));
        chk({tag, ".b"}, 32'(b), 32'(eb));
        chk({tag, ".op_valid"}, 32'(op_valid), 32'(eov));
        chk({tag, ".window_full"}, 32'(window_full), 32'(efull));
        chk({tag, ".fill_count"}, 32'(fill_count), 32'(efill));
    endtask

    // Samples 1..n back-to-back from an empty window with op_ready held high.
    task automatic run_stream(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(k), 1'b1);
            chk($sformatf("%s[%0d].in_ready", tag, k), 32'(in_ready), 32'd1);
            tick();
            chk_outs($sformatf("%s[%0d]", tag, k), 8'(k), (k > 16) ? 8'(k - 16) : 8'd0,
                     1'b1, k >= 16, (k >= 16) ? 5'd16 : 5'(k));
        end
    endtask

    initial begin
        // After samples 1..40: a=40, b=24, window full, wr_ptr at slot 8 (holds 25).
        tbl[0]  = '{1'b0, 1'b1, 8'd41,  1'b0, 1'b0, 8'd40,  8'd24, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'd41,  1'b0, 1'b0, 8'd40,  8'd24, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'd41,  1'b0, 1'b0, 8'd40,  8'd24, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 8'd41,  1'b1, 1'b1, 8'd41,  8'd25, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'd42,  1'b1, 1'b1, 8'd42,  8'd26, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 8'd42,  8'd26, 1'b0, 1'b1, 5'd16, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 8'd42,  8'd26, 1'b0, 1'b1, 5'd16, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'd43,  1'b0, 1'b1, 8'd43,  8'd27, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 8'd99,  1'b1, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 5'd0,  1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'd200, 1'b1, 1'b1, 8'd200, 8'd0,  1'b1, 1'b0, 5'd1,  1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'd201, 1'b1, 1'b1, 8'd201, 8'd0,  1'b1, 1'b0, 5'd2,  1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 8'd201, 8'd0,  1'b0, 1'b0, 5'd2,  1'b1};

        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_outs("rst", 8'd0, 8'd0, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("idle.in_ready", 32'(in_ready), 32'd1);
        tick();

        run_stream("fill", 40);

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            tick();
            if (tbl[i].chk_ab) begin
                chk($sformatf("vec%0d.a", i), 32'(a), 32'(tbl[i].ea));
                chk($sformatf("vec%0d.b", i), 32'(b), 32'(tbl[i].eb));
            end
            chk($sformatf("vec%0d.op_valid", i), 32'(op_valid), 32'(tbl[i].eov));
            chk($sformatf("vec%0d.window_full", i), 32'(window_full), 32'(tbl[i].efull));
            chk($sformatf("vec%0d.fill_count", i), 32'(fill_count), 32'(tbl[i].efill));
        end

        // Reset while a pair is stalled downstream.
        drive(1'b0, 1'b0, 1'b1, 8'd202, 1'b1);
        tick();
        chk_outs("pend", 8'd202, 8'd0, 1'b1, 1'b0, 5'd3);
        drive(1'b1, 1'b0, 1'b1, 8'd77, 1'b0);
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_outs("midrst", 8'd0, 8'd0, 1'b0, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("postrst.in_ready", 32'(in_ready), 32'd1);
        tick();

        run_stream("refill", 17);

        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
